mem_dma: RTL and testbench

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma_pkg.sv | 17 +
 rtl/mem_dma.sv | 137 +++++++++++++
 tb/tb_mem_dma.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared definitions for the memory-to-memory DMA engine.
//   dmaState_t   : FSM state encoding (IDLE, READ, WRITE, DONE)
//   ADR_W_DEF    : default memory address width
//   DATA_W_DEF   : default memory word width (matches the 64-bit single-port RAM)
package mem_dma_pkg;

  localparam int ADR_W_DEF  = 16;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dmaState_t;

endpackage

// File: rtl/mem_dma.sv
// mem_dma: copy/fill DMA engine driving a single-port RAM with combinational
// read data.
//
// Ports
//   clk, resetN          clock, synchronous active-low reset
//   start, abort, mode   control (mode 0 = copy, 1 = fill)
//   srcAdr, dstAdr, len  transfer descriptor, latched when start is taken in IDLE
//   fillData             pattern for fill mode
//   busy, done           status (busy in READ/WRITE, done pulses one cycle)
//   wordsDone, checksum  progress of the current or last transfer
//   adr, writeData,
//   writeEn, readData    RAM port
//   dbgState             current FSM state, for observation only
//
// Handshake: a transfer is requested by holding start=1 while busy=0 and the
// engine is in IDLE; start is accepted at that posedge and ignored at all other
// times. abort=1 in READ/WRITE suppresses that cycle's write and returns to
// IDLE without a done pulse.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADR_W  = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADR_W-1:0]  srcAdr,
  input  logic [ADR_W-1:0]  dstAdr,
  input  logic [ADR_W-1:0]  len,
  input  logic [DATA_W-1:0] fillData,
  output logic              busy,
  output logic              done,
  output logic [ADR_W-1:0]  wordsDone,
  output logic [DATA_W-1:0] checksum,
  output logic [ADR_W-1:0]  adr,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEn,
  input  logic [DATA_W-1:0] readData,
  output dmaState_t         dbgState
);

  dmaState_t         state;
  dmaState_t         nextState;
  logic [ADR_W-1:0]  srcReg;
  logic [ADR_W-1:0]  dstReg;
  logic [ADR_W-1:0]  lenReg;
  logic              modeReg;
  logic [DATA_W-1:0] fillReg;
  logic [DATA_W-1:0] buffer;
  // Word index; every completed write advances it, so it doubles as wordsDone.
  logic [ADR_W-1:0]  idx;
  logic [ADR_W-1:0]  idxNext;

  assign idxNext   = idx + 1'b1;
  assign wordsDone = idx;
  assign busy      = (state == READ) || (state == WRITE);
  assign done      = (state == DONE);
  assign dbgState  = state;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= IDLE;
      srcReg   <= '0;
      dstReg   <= '0;
      lenReg   <= '0;
      modeReg  <= 1'b0;
      fillReg  <= '0;
      buffer   <= '0;
      idx      <= '0;
      checksum <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            srcReg   <= srcAdr;
            dstReg   <= dstAdr;
            lenReg   <= len;
            modeReg  <= mode;
            fillReg  <= fillData;
            idx      <= '0;
            checksum <= '0;
          end
        end
        READ: begin
          if (!abort) buffer <= readData;
        end
        WRITE: begin
          // An aborted write never reaches the RAM, so it is not counted.
          if (!abort) begin
            idx      <= idxNext;
            checksum <= checksum ^ writeData;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    adr       = '0;
    writeData = '0;
    writeEn   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)  nextState = DONE;
          else if (mode)  nextState = WRITE;
          else            nextState = READ;
        end
      end
      READ: begin
        adr       = srcReg + idx;
        nextState = abort ? IDLE : WRITE;
      end
      WRITE: begin
        // Address sum wraps modulo 2^ADR_W by truncation.
        adr       = dstReg + idx;
        writeData = modeReg ? fillReg : buffer;
        writeEn   = !abort;
        if (abort)                 nextState = IDLE;
        else if (idxNext == lenReg) nextState = DONE;
        else if (modeReg)          nextState = WRITE;
        else                       nextState = READ;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed scoreboard bench for mem_dma with a behavioural RAM.
module tb_mem_dma;
  import mem_dma_pkg::*;

  localparam int ADR_W  = 16;
  localparam int DATA_W = 64;

  logic              clk;
  logic              resetN;
  logic              start;
  logic              abort;
  logic              mode;
  logic [ADR_W-1:0]  srcAdr;
  logic [ADR_W-1:0]  dstAdr;
  logic [ADR_W-1:0]  len;
  logic [DATA_W-1:0] fillData;
  logic              busy;
  logic              done;
  logic [ADR_W-1:0]  wordsDone;
  logic [DATA_W-1:0] checksum;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] writeData;
  logic              writeEn;
  logic [DATA_W-1:0] readData;
  dmaState_t         dbgState;

  mem_dma #(.ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetN(resetN), .start(start), .abort(abort), .mode(mode),
    .srcAdr(srcAdr), .dstAdr(dstAdr), .len(len), .fillData(fillData),
    .busy(busy), .done(done), .wordsDone(wordsDone), .checksum(checksum),
    .adr(adr), .writeData(writeData), .writeEn(writeEn), .readData(readData),
    .dbgState(dbgState)
  );

  // ---------------- clock / reset / RAM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:65535];
  assign readData = mem[adr];
  always @(posedge clk) if (writeEn) mem[adr] <= writeData;

  int cyc = 0;
  int startCyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int total  = 0;
  int passed = 0;
  logic [ADR_W+DATA_W-1:0]    exp_q[$];       // {adr, data} of each expected write
  logic [16+ADR_W+DATA_W-1:0] exp_done_q[$];  // {latency, wordsDone, checksum}
  logic busySeen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (busy) busySeen = 1'b1;
    if (writeEn) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_adr", 64'(adr), 64'hDEAD);
      end else begin
        logic [ADR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("write_adr", 64'(adr), 64'(e[ADR_W+DATA_W-1:DATA_W]));
        check("write_data", writeData, e[DATA_W-1:0]);
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        check("unexpected_done", 64'(cyc - startCyc), 64'hDEAD);
      end else begin
        logic [16+ADR_W+DATA_W-1:0] d;
        d = exp_done_q.pop_front();
        check("done_latency", 64'(cyc - startCyc), 64'(d[16+ADR_W+DATA_W-1:ADR_W+DATA_W]));
        check("done_wordsDone", 64'(wordsDone), 64'(d[ADR_W+DATA_W-1:DATA_W]));
        check("done_checksum", checksum, d[DATA_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    repeat (n) tick();
  endtask

  task automatic expWrite(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic expDone(input int lat, input logic [ADR_W-1:0] w, input logic [DATA_W-1:0] c);
    exp_done_q.push_back({16'(lat), w, c});
  endtask

  // Drives start for one cycle; returns just after the accepting edge.
  task automatic startXfer(input logic m, input logic [ADR_W-1:0] s, input logic [ADR_W-1:0] d,
                           input logic [ADR_W-1:0] l, input logic [DATA_W-1:0] f);
    mode = m; srcAdr = s; dstAdr = d; len = l; fillData = f;
    start = 1'b1;
    startCyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic checkDrained(input string name);
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_dones_left"}, 64'(exp_done_q.size()), 64'd0);
    exp_q.delete();
    exp_done_q.delete();
  endtask

  task automatic checkAllZero(input string name);
    @(negedge clk);
    check({name, "_state"}, 64'(dbgState), 64'(IDLE));
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_writeEn"}, 64'(writeEn), 64'd0);
    check({name, "_adr"}, 64'(adr), 64'd0);
    check({name, "_writeData"}, writeData, 64'd0);
    check({name, "_wordsDone"}, 64'(wordsDone), 64'd0);
    check({name, "_checksum"}, checksum, 64'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    resetN = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    srcAdr = '0; dstAdr = '0; len = '0; fillData = '0;
    tickN(3);
    checkAllZero("reset");
    resetN = 1'b1;
    tickN(2);

    // Copy: 4 words 0..3 -> 100..103.
    mem[0] = 64'd10; mem[1] = 64'd20; mem[2] = 64'd30; mem[3] = 64'd40;
    expWrite(16'd100, 64'd10); expWrite(16'd101, 64'd20);
    expWrite(16'd102, 64'd30); expWrite(16'd103, 64'd40);
    expDone(9, 16'd4, 64'd40);  // 10^20^30^40 = 40
    startXfer(1'b0, 16'd0, 16'd100, 16'd4, 64'd0);
    tickN(12);
    checkDrained("copy");
    for (int i = 0; i < 4; i++) check("copy_mem", mem[100 + i], 64'(10 * (i + 1)));

    // Fill across the top of the address space.
    expWrite(16'hFFFE, 64'hA5); expWrite(16'hFFFF, 64'hA5); expWrite(16'h0000, 64'hA5);
    expDone(4, 16'd3, 64'hA5);  // A5^A5^A5 = A5
    startXfer(1'b1, 16'd0, 16'hFFFE, 16'd3, 64'hA5);
    tickN(8);
    checkDrained("fill");
    check("fill_mem_0", mem[0], 64'hA5);

    // Zero length: immediate done, never busy, no writes.
    busySeen = 1'b0;
    expDone(1, 16'd0, 64'd0);
    startXfer(1'b0, 16'd5, 16'd6, 16'd0, 64'd0);
    tickN(4);
    checkDrained("zero");
    check("zero_busy_seen", 64'(busySeen), 64'd0);

    // Abort during the third WRITE of an 8-word copy.
    for (int i = 0; i < 8; i++) mem[i] = 64'(8'h11 * (i + 1));
    expWrite(16'd200, 64'h11); expWrite(16'd201, 64'h22);
    startXfer(1'b0, 16'd0, 16'd200, 16'd8, 64'd0);
    tickN(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_state", 64'(dbgState), 64'(IDLE));
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_wordsDone", 64'(wordsDone), 64'd2);
    check("abort_checksum", checksum, 64'h33);
    tickN(4);
    checkDrained("abort");
    check("abort_mem_202", mem[202], 64'd0);

    // Overlapping forward copy smears word 0.
    mem[0] = 64'd1; mem[1] = 64'd2; mem[2] = 64'd3; mem[3] = 64'd4;
    expWrite(16'd1, 64'd1); expWrite(16'd2, 64'd1); expWrite(16'd3, 64'd1);
    expDone(7, 16'd3, 64'd1);
    startXfer(1'b0, 16'd0, 16'd1, 16'd3, 64'd0);
    tickN(10);
    checkDrained("overlap");
    for (int i = 0; i < 4; i++) check("overlap_mem", mem[i], 64'd1);

    // Start while busy is ignored; reset mid-copy stops everything.
    mem[0] = 64'd10; mem[1] = 64'd20; mem[2] = 64'd30; mem[3] = 64'd40;
    expWrite(16'd300, 64'd10); expWrite(16'd301, 64'd20);
    startXfer(1'b0, 16'd0, 16'd300, 16'd4, 64'd0);
    tick();
    start = 1'b1; mode = 1'b1; dstAdr = 16'd500; len = 16'd9; fillData = 64'hFF;
    tickN(2);
    start = 1'b0;
    tick();
    resetN = 1'b0;
    tick();
    checkAllZero("midreset");
    resetN = 1'b1;
    tickN(4);
    checkDrained("midreset");
    check("midreset_mem_302", mem[302], 64'd0);
    check("busy_start_mem_500", mem[500], 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
